multi_dataflow_mul_mdc_engine_adapter: RTL

- Engine-side responder of the ctrl_engine/flags_engine protocol for the multi_dataflow_mul_mdc HWPE.
- Consumes ctrl_engine_multi_dataflow_mul_mdc_t from the controller FSM and returns flags_engine_multi_dataflow_mul_mdc_t.
- Drives the MDC kernel start and configuration, gates the three input streams and the one output stream into and out of the kernel, and counts accepted outStream0 beats against cnt_limit_outStream0.

---
 rtl/multi_dataflow_mul_mdc_package.sv | 28 ++
 rtl/multi_dataflow_mul_mdc_beat_counter.sv | 34 +++
 rtl/multi_dataflow_mul_mdc_engine_adapter.sv | 100 ++++++++++
 3 files changed

// File: rtl/multi_dataflow_mul_mdc_package.sv
// multi_dataflow_mul_mdc_package: shared constants, engine/kernel-adapter structs and engine adapter states
package multi_dataflow_mul_mdc_package;
   localparam int MULTI_DATAFLOW_MUL_MDC_CNT_LEN = 1024;
   localparam int MULTI_DATAFLOW_MUL_MDC_CNT_W = $clog2(MULTI_DATAFLOW_MUL_MDC_CNT_LEN) + 1;
   typedef struct packed {
      logic clear;
      logic enable;
      logic start;
      logic [MULTI_DATAFLOW_MUL_MDC_CNT_W-1:0] cnt_limit_outStream0;
      logic [31:0] reg_simple_mul;
      logic [31:0] reg_shift;
      logic [31:0] reg_len;
   } ctrl_engine_multi_dataflow_mul_mdc_t;
   typedef struct packed {
      logic [MULTI_DATAFLOW_MUL_MDC_CNT_W-1:0] cnt_outStream0;
      logic done;
      logic ready;
   } flags_engine_multi_dataflow_mul_mdc_t;
   typedef struct packed {
      logic start;
   } ctrl_kernel_adapter_multi_dataflow_mul_mdc_t;
   typedef struct packed {
      logic done;
      logic idle;
      logic ready;
   } flags_kernel_adapter_multi_dataflow_mul_mdc_t;
   typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, DONE} state_engine_adapter_t;
endpackage

// File: rtl/multi_dataflow_mul_mdc_beat_counter.sv
// multi_dataflow_mul_mdc_beat_counter: saturating beat counter with latched limit and terminal flags
module multi_dataflow_mul_mdc_beat_counter #(
   parameter int CW = 11
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          load_i,
   input  logic [CW-1:0] lim_i,
   input  logic          inc_i,
   output logic [CW-1:0] cnt_o,
   output logic          term_o,
   output logic          hit_o
);
   logic [CW-1:0] cnt_q, cnt_d, lim_q, lim_d;
   logic step;
   always_comb begin
      term_o = cnt_q == lim_q;
      step = inc_i && !term_o;
      hit_o = step && (cnt_q + CW'(1) == lim_q);
      lim_d = load_i ? lim_i : lim_q;
      cnt_d = load_i ? '0 : step ? cnt_q + CW'(1) : cnt_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt_q <= '0;
         lim_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         lim_q <= lim_d;
      end
   end
   assign cnt_o = cnt_q;
endmodule

// File: rtl/multi_dataflow_mul_mdc_engine_adapter.sv
// multi_dataflow_mul_mdc_engine_adapter: engine-side ctrl/flags responder that starts the kernel and gates its streams
module multi_dataflow_mul_mdc_engine_adapter
   import multi_dataflow_mul_mdc_package::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NB_IN = 3,
   parameter int CNT_LEN = MULTI_DATAFLOW_MUL_MDC_CNT_LEN
) (
   input  logic                                          clk_i,
   input  logic                                          rst_i,
   input  ctrl_engine_multi_dataflow_mul_mdc_t           ctrl_i,
   output flags_engine_multi_dataflow_mul_mdc_t          flags_o,
   input  logic [NB_IN*DATA_WIDTH-1:0]                   in_data_i,
   input  logic [NB_IN-1:0]                              in_valid_i,
   output logic [NB_IN-1:0]                              in_ready_o,
   output logic [NB_IN*DATA_WIDTH-1:0]                   k_in_data_o,
   output logic [NB_IN-1:0]                              k_in_valid_o,
   input  logic [NB_IN-1:0]                              k_in_ready_i,
   input  logic [DATA_WIDTH-1:0]                         k_out_data_i,
   input  logic                                          k_out_valid_i,
   output logic                                          k_out_ready_o,
   output logic [DATA_WIDTH-1:0]                         out_data_o,
   output logic                                          out_valid_o,
   input  logic                                          out_ready_i,
   output ctrl_kernel_adapter_multi_dataflow_mul_mdc_t   k_ctrl_o,
   input  flags_kernel_adapter_multi_dataflow_mul_mdc_t  k_flags_i,
   output logic [3*32-1:0]                               k_cfg_o
);
   localparam int CW = $clog2(CNT_LEN) + 1;
   state_engine_adapter_t state_q;
   logic done_q, ready_q, kstart_q;
   logic [3*32-1:0] cfg_q;
   logic go, run_en, open, term, hit, unused_kdone;
   logic [CW-1:0] cnt;
   assign go = ctrl_i.start && ctrl_i.enable;
   assign run_en = state_q == RUN && ctrl_i.enable;
   // Once the limit is reached no further result beat may slip through
   assign open = run_en && !term;
   assign unused_kdone = k_flags_i.done;
   multi_dataflow_mul_mdc_beat_counter #(.CW(CW)) u_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (ctrl_i.clear),
      .load_i (state_q == IDLE && go),
      .lim_i  (CW'(ctrl_i.cnt_limit_outStream0)),
      .inc_i  (out_valid_o && out_ready_i),
      .cnt_o  (cnt),
      .term_o (term),
      .hit_o  (hit)
   );
   always_ff @(posedge clk_i) begin
      if (rst_i || ctrl_i.clear) begin
         state_q  <= IDLE;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
         kstart_q <= 1'b0;
         if (rst_i) cfg_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (go) begin
               cfg_q   <= {ctrl_i.reg_len, ctrl_i.reg_shift, ctrl_i.reg_simple_mul};
               ready_q <= 1'b0;
               if (ctrl_i.cnt_limit_outStream0 == '0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q  <= START;
                  kstart_q <= 1'b1;
               end
            end
            START: if (k_flags_i.ready) begin
               state_q  <= RUN;
               kstart_q <= 1'b0;
            end
            RUN: if (hit) state_q <= DRAIN;
            DRAIN: if (k_flags_i.idle) begin
               state_q <= DONE;
               done_q  <= 1'b1;
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign k_in_data_o = in_data_i;
   assign k_in_valid_o = run_en ? in_valid_i : '0;
   assign in_ready_o = run_en ? k_in_ready_i : '0;
   assign out_data_o = k_out_data_i;
   assign out_valid_o = open && k_out_valid_i;
   assign k_out_ready_o = open && out_ready_i;
   assign k_ctrl_o.start = kstart_q;
   assign k_cfg_o = cfg_q;
   assign flags_o.cnt_outStream0 = MULTI_DATAFLOW_MUL_MDC_CNT_W'(cnt);
   assign flags_o.done = done_q;
   assign flags_o.ready = ready_q;
endmodule
